// File: rtl/mem_wb_stage_if.sv
// Data-memory request bus between the MEM stage and the datapath/cache port.
interface mem_wb_stage_if #(
  parameter int WORD_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage: issues data-memory requests, stalls until dhit, and owns the
// MEM/WB register, the sticky halt and a saturating stall-cycle counter.
//
// state  | meaning
// IDLE   | requests driven from the EX/MEM register, stall until dhit
// DONE   | access finished while MEM/WB was frozen; load data kept in hold
// HALTED | halt retired; no further requests or register writes
module mem_wb_stage #(
  parameter int WORD_W = 32,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memcuDRE,
  input  logic              memcuDWE,
  input  logic              memcuHALT,
  input  logic              memMemToReg,
  input  logic              memWEN,
  input  logic [SEL_W-1:0]  memwsel,
  input  logic [WORD_W-1:0] memOutput_Port,
  input  logic [WORD_W-1:0] memrdat2,
  input  logic [WORD_W-1:0] meminstr,
  input  logic              wbW,
  input  logic              wbRST,
  mem_wb_stage_if.master    dmem,
  output logic              mem_stall,
  output logic              wbWEN,
  output logic [SEL_W-1:0]  wbwsel,
  output logic [WORD_W-1:0] wbwdat,
  output logic [WORD_W-1:0] wbinstr,
  output logic              wbHALT,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, DONE, HALTED} state_t;

  state_t            state, nextState;
  logic              reqRead, reqWrite;
  logic              capture, latchHold;
  logic [WORD_W-1:0] hold, wbdataNext;

  // Requests are gated by nRST so they drop the instant reset asserts.
  assign reqWrite = (state == IDLE) & nRST & memcuDWE;
  assign reqRead  = (state == IDLE) & nRST & memcuDRE & ~memcuDWE;

  assign dmem.dmemREN   = reqRead;
  assign dmem.dmemWEN   = reqWrite;
  assign dmem.dmemaddr  = memOutput_Port;
  assign dmem.dmemstore = memrdat2;

  assign mem_stall = (reqRead | reqWrite) & ~dmem.dhit;
  assign capture   = wbW & ~mem_stall;

  always_comb begin
    nextState  = state;
    latchHold  = 1'b0;
    wbdataNext = memOutput_Port;
    if (memMemToReg)
      wbdataNext = (state == DONE) ? hold : dmem.dmemload;

    if (wbRST) begin
      if (state != HALTED)
        nextState = IDLE;
    end else if (capture) begin
      if (memcuHALT || state == HALTED)
        nextState = HALTED;
      else
        nextState = IDLE;
    end else if (state == IDLE && dmem.dhit && (reqRead || reqWrite)) begin
      nextState = DONE;
      latchHold = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= nextState;
      if (latchHold)
        hold <= dmem.dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wbWEN   <= 1'b0;
      wbwsel  <= '0;
      wbwdat  <= '0;
      wbinstr <= '0;
      wbHALT  <= 1'b0;
    end else if (wbRST) begin
      wbWEN   <= 1'b0;
      wbwsel  <= '0;
      wbwdat  <= '0;
      wbinstr <= '0;
    end else if (capture) begin
      wbWEN   <= memWEN & (state != HALTED);
      wbwsel  <= memwsel;
      wbwdat  <= wbdataNext;
      wbinstr <= meminstr;
      wbHALT  <= wbHALT | memcuHALT;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if (mem_stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
